dma_ring_ctrl: RTL and testbench

- Command generator that sits directly upstream of the DMA writer's command port, in the DMA clock domain.
- Splits a circular SDRAM region into NUM_BUFS equal buffers and issues one start command per buffer, in ring order.
- Tracks completions from the DMA's DONE_CNT and reports each finished buffer index to the host.
- Issues a buffer only after the host has released it, so unread data is never overwritten.

---
 rtl/dma_ring_ctrl_if.sv | 26 ++
 rtl/dma_ring_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dma_ring_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_ring_ctrl_if.sv
// DMA command-port bundle between the ring controller and the DMA writer.
interface dma_ring_ctrl_if;
    logic [27:0] DMA_START_ADR;
    logic [27:0] DMA_BUF_SIZE;
    logic        DMA_START;
    logic [15:0] DMA_DONE_CNT;
    logic        DMA_CMD_FIFO_AEMPTY;

    // Controller side: issues commands, observes completion counter and FIFO level
    modport master (
        output DMA_START_ADR,
        output DMA_BUF_SIZE,
        output DMA_START,
        input  DMA_DONE_CNT,
        input  DMA_CMD_FIFO_AEMPTY
    );

    // DMA side: accepts commands, reports completions and FIFO level
    modport slave (
        input  DMA_START_ADR,
        input  DMA_BUF_SIZE,
        input  DMA_START,
        output DMA_DONE_CNT,
        output DMA_CMD_FIFO_AEMPTY
    );
endinterface

// File: rtl/dma_ring_ctrl.sv
// Ring-buffer command generator for the DMA writer.
// Issues one start command per buffer in ring order, gated by host credits,
// outstanding-command limit and DMA FIFO level; turns DMA_DONE_CNT steps
// into per-buffer completion pulses.
module dma_ring_ctrl #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned IDX_W           = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic [27:0]      BASE_ADR,
    input  logic [27:0]      BUF_SIZE,
    input  logic [IDX_W-1:0] NUM_BUFS,
    input  logic             HOST_REL,
    dma_ring_ctrl_if.master  dma,
    output logic             BUF_DONE,
    output logic [IDX_W-1:0] DONE_IDX,
    output logic [3:0]       OUTSTANDING,
    output logic             BUSY,
    output logic             ERR
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DRAIN
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [3:0]       OUT_MAX = 4'(MAX_OUTSTANDING);

    state_t           state;
    logic [27:0]      base_q;
    logic [27:0]      size_q;
    logic [27:0]      adr_q;
    logic [IDX_W-1:0] n_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] free_q;
    logic [15:0]      done_seen;

    logic             done_pend;
    logic             comp_ok;
    logic             issue;
    logic             rel_ok;
    logic             rel_err;
    logic [IDX_W-1:0] n_in;

    // Event decode for the current cycle: completion, issue and host release
    always_comb begin
        done_pend = (done_seen != dma.DMA_DONE_CNT);
        comp_ok   = done_pend && (OUTSTANDING != 4'd0);
        issue     = (state == RUN) && ENABLE && (free_q != '0) &&
                    (OUTSTANDING < OUT_MAX) && dma.DMA_CMD_FIFO_AEMPTY;
        rel_ok    = HOST_REL && (state != IDLE) && (free_q != n_q);
        rel_err   = HOST_REL && (state != IDLE) && (free_q == n_q);
        n_in      = (NUM_BUFS == '0) ? IDX_ONE : NUM_BUFS;
    end

    assign BUSY = (state != IDLE);

    // Ring FSM with completion tracking, credit and outstanding accounting
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state             <= IDLE;
            base_q            <= '0;
            size_q            <= '0;
            adr_q             <= '0;
            n_q               <= '0;
            wr_idx            <= '0;
            rd_idx            <= '0;
            free_q            <= '0;
            done_seen         <= '0;
            OUTSTANDING       <= '0;
            BUF_DONE          <= 1'b0;
            DONE_IDX          <= '0;
            ERR               <= 1'b0;
            dma.DMA_START     <= 1'b0;
            dma.DMA_START_ADR <= '0;
            dma.DMA_BUF_SIZE  <= '0;
        end else begin
            dma.DMA_START <= 1'b0;
            BUF_DONE      <= 1'b0;

            if (done_pend) begin
                done_seen <= done_seen + 16'd1;
                if (comp_ok) begin
                    BUF_DONE <= 1'b1;
                    DONE_IDX <= rd_idx;
                    rd_idx   <= (rd_idx == n_q - IDX_ONE) ? '0 : rd_idx + IDX_ONE;
                end
            end

            case ({issue, comp_ok})
                2'b10:   OUTSTANDING <= OUTSTANDING + 4'd1;
                2'b01:   OUTSTANDING <= OUTSTANDING - 4'd1;
                default: OUTSTANDING <= OUTSTANDING;
            endcase

            case ({issue, rel_ok})
                2'b10:   free_q <= free_q - IDX_ONE;
                2'b01:   free_q <= free_q + IDX_ONE;
                default: free_q <= free_q;
            endcase

            if (rel_err) begin
                ERR <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ENABLE) begin
                        base_q <= BASE_ADR;
                        size_q <= BUF_SIZE;
                        n_q    <= n_in;
                        adr_q  <= BASE_ADR;
                        wr_idx <= '0;
                        rd_idx <= '0;
                        free_q <= n_in;
                        ERR    <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        dma.DMA_START     <= 1'b1;
                        dma.DMA_START_ADR <= adr_q;
                        dma.DMA_BUF_SIZE  <= size_q;
                        state             <= GAP;
                    end else if (!ENABLE) begin
                        state <= DRAIN;
                    end
                end
                GAP: begin
                    if (wr_idx == n_q - IDX_ONE) begin
                        wr_idx <= '0;
                        adr_q  <= base_q;
                    end else begin
                        wr_idx <= wr_idx + IDX_ONE;
                        adr_q  <= adr_q + size_q;
                    end
                    state <= RUN;
                end
                DRAIN: begin
                    if (OUTSTANDING == 4'd0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the IDLE-exit clear so a stale completion in that
            // same cycle still leaves ERR set.
            if (done_pend && !comp_ok) begin
                ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_ring_ctrl.sv
// Scoreboard bench for dma_ring_ctrl: stimulus pushes expected command
// addresses and completion indices, an independent monitor pops and compares.
module tb_dma_ring_ctrl;

    localparam int unsigned MAXO  = 2;
    localparam int unsigned IDX_W = 8;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ENABLE;
    logic [27:0] BASE_ADR;
    logic [27:0] BUF_SIZE;
    logic [7:0]  NUM_BUFS;
    logic        HOST_REL;
    logic        BUF_DONE;
    logic [7:0]  DONE_IDX;
    logic [3:0]  OUTSTANDING;
    logic        BUSY;
    logic        ERR;

    dma_ring_ctrl_if dma_if ();

    dma_ring_ctrl #(
        .MAX_OUTSTANDING(MAXO),
        .IDX_W(IDX_W)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .ENABLE(ENABLE),
        .BASE_ADR(BASE_ADR),
        .BUF_SIZE(BUF_SIZE),
        .NUM_BUFS(NUM_BUFS),
        .HOST_REL(HOST_REL),
        .dma(dma_if),
        .BUF_DONE(BUF_DONE),
        .DONE_IDX(DONE_IDX),
        .OUTSTANDING(OUTSTANDING),
        .BUSY(BUSY),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // scoreboard queues
    logic [27:0] exp_start_q[$];
    logic [7:0]  exp_idx_q[$];

    // reference model state
    logic [27:0] cfg_base;
    logic [27:0] cfg_size;
    int          cfg_n;
    int          pushed;
    int          comp_k;
    int          total_limit;
    int          pend_rel;

    // DMA/host environment knobs
    int due_q[$];
    int cyc = 0;
    int auto_dma = 0;
    int auto_rel = 0;
    int lat_min = 4;
    int lat_max = 4;
    int rel_pct = 100;
    int aempty_pct = 100;

    // monitor statistics
    int start_cnt = 0;
    int bd_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Expected address of the k-th command: ring position k mod n, plain arithmetic
    task automatic push_start();
        longint a;
        a = longint'(cfg_base) + longint'(pushed % cfg_n) * longint'(cfg_size);
        exp_start_q.push_back(28'(a));
        pushed++;
    endtask

    task automatic add_done(input int k);
        for (int i = 0; i < k; i++) begin
            dma_if.DMA_DONE_CNT = dma_if.DMA_DONE_CNT + 16'd1;
            exp_idx_q.push_back(8'(comp_k % cfg_n));
            comp_k++;
        end
    endtask

    // One clock of environment: DMA completion responder, host releases, FIFO level
    task automatic step();
        int d;
        @(negedge CLK);
        cyc++;
        HOST_REL = 1'b0;
        if (auto_dma != 0 && dma_if.DMA_START === 1'b1) begin
            d = cyc + $urandom_range(lat_max, lat_min);
            if (due_q.size() > 0 && d <= due_q[$]) d = due_q[$] + 1;
            due_q.push_back(d);
        end
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            add_done(1);
        end
        if (auto_rel != 0 && BUF_DONE === 1'b1) pend_rel++;
        if (auto_rel != 0 && pend_rel > 0 && pushed < total_limit &&
            $urandom_range(99) < rel_pct) begin
            HOST_REL = 1'b1;
            pend_rel--;
            push_start();
        end
        dma_if.DMA_CMD_FIFO_AEMPTY = ($urandom_range(99) < aempty_pct);
    endtask

    task automatic start_run(input logic [27:0] b, input logic [27:0] s, input logic [7:0] nb);
        BASE_ADR = b;
        BUF_SIZE = s;
        NUM_BUFS = nb;
        cfg_base = b;
        cfg_size = s;
        cfg_n    = (nb == 8'd0) ? 1 : int'(nb);
        pushed   = 0;
        comp_k   = 0;
        pend_rel = 0;
        ENABLE   = 1'b1;
    endtask

    task automatic stop_run();
        int t;
        ENABLE = 1'b0;
        t = 0;
        while ((BUSY === 1'b1 || t == 0) && t < 2000) begin
            step();
            t++;
        end
        chk("drain_to_idle", BUSY, 0);
        repeat (2) step();
    endtask

    task automatic run_ring(input logic [27:0] b, input logic [27:0] s, input logic [7:0] nb,
                            input int total, input int lmin, input int lmax,
                            input int rpct, input int apct);
        int t;
        int d0;
        auto_dma    = 1;
        auto_rel    = 1;
        lat_min     = lmin;
        lat_max     = lmax;
        rel_pct     = rpct;
        aempty_pct  = apct;
        total_limit = total;
        d0          = bd_cnt;
        start_run(b, s, nb);
        while (pushed < cfg_n && pushed < total) push_start();
        t = 0;
        while ((exp_start_q.size() != 0 || pushed < total) && t < 4000) begin
            step();
            t++;
        end
        chk("run_starts_in_time", t < 4000, 1);
        stop_run();
        chk("run_err_clear", ERR, 0);
        chk("run_done_count", bd_cnt - d0, total);
        chk("run_idx_q_empty", exp_idx_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_start"}, dma_if.DMA_START, 0);
        chk({tag, "_start_adr"}, dma_if.DMA_START_ADR, 0);
        chk({tag, "_buf_size"}, dma_if.DMA_BUF_SIZE, 0);
        chk({tag, "_buf_done"}, BUF_DONE, 0);
        chk({tag, "_done_idx"}, DONE_IDX, 0);
        chk({tag, "_outstanding"}, OUTSTANDING, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_err"}, ERR, 0);
    endtask

    // Monitor: compares DUT outputs against the scoreboard whenever they are presented
    initial begin
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1) begin
                if (dma_if.DMA_START === 1'b1) begin
                    start_cnt++;
                    chk("start_spacing", prev_start, 0);
                    chk("start_expected", exp_start_q.size() != 0, 1);
                    if (exp_start_q.size() != 0) begin
                        chk("start_adr", dma_if.DMA_START_ADR, exp_start_q.pop_front());
                    end
                    chk("start_size", dma_if.DMA_BUF_SIZE, cfg_size);
                end
                if (BUF_DONE === 1'b1) begin
                    bd_cnt++;
                    chk("done_expected", exp_idx_q.size() != 0, 1);
                    if (exp_idx_q.size() != 0) begin
                        chk("done_idx", DONE_IDX, exp_idx_q.pop_front());
                    end
                end
                chk("outstanding_le_max", OUTSTANDING <= 4'(MAXO), 1);
                prev_start = dma_if.DMA_START;
            end else begin
                prev_start = 1'b0;
            end
        end
    end

    // Stimulus
    initial begin
        int s0;
        int t;
        int nb;
        int tot;

        RST_N = 1'b0;
        ENABLE = 1'b0;
        BASE_ADR = '0;
        BUF_SIZE = '0;
        NUM_BUFS = '0;
        HOST_REL = 1'b0;
        dma_if.DMA_DONE_CNT = '0;
        dma_if.DMA_CMD_FIFO_AEMPTY = 1'b1;
        cfg_base = '0;
        cfg_size = '0;
        cfg_n = 1;
        pushed = 0;
        comp_k = 0;
        total_limit = 0;
        pend_rel = 0;

        repeat (3) @(negedge CLK);
        check_zero("reset");
        RST_N = 1'b1;
        step();

        // Ring order with immediate host release, fixed 4-cycle DMA latency
        run_ring(28'h0100000, 28'h0001000, 8'd3, 4, 4, 4, 100, 100);

        // No host release: credits run out after n commands
        auto_dma = 1; auto_rel = 0; lat_min = 4; lat_max = 4; aempty_pct = 100;
        s0 = start_cnt;
        start_run(28'h0100000, 28'h0001000, 8'd3);
        repeat (3) push_start();
        step();
        chk("enable_lat_cycle1", dma_if.DMA_START, 0);
        step();
        chk("enable_lat_cycle2", dma_if.DMA_START, 1);
        repeat (40) step();
        chk("no_rel_start_count", start_cnt - s0, 3);
        chk("no_rel_outstanding", OUTSTANDING, 0);
        chk("no_rel_busy", BUSY, 1);
        chk("start_adr_hold", dma_if.DMA_START_ADR, 28'h0102000);
        push_start();
        HOST_REL = 1'b1;
        repeat (20) step();
        chk("one_rel_start_count", start_cnt - s0, 4);
        stop_run();

        // Outstanding limit with frozen DONE_CNT, then a burst of two completions
        auto_dma = 0; auto_rel = 0; aempty_pct = 100;
        s0 = start_cnt;
        start_run(28'h0200000, 28'h0000080, 8'd4);
        repeat (2) push_start();
        repeat (20) step();
        chk("limit_start_count", start_cnt - s0, MAXO);
        chk("limit_outstanding", OUTSTANDING, MAXO);
        aempty_pct = 0;
        step();
        add_done(2);
        step();
        chk("burst_done_1", BUF_DONE, 1);
        step();
        chk("burst_done_2", BUF_DONE, 1);
        chk("burst_outstanding", OUTSTANDING, 0);

        // Drain with two commands in flight
        aempty_pct = 100;
        repeat (2) push_start();
        t = 0;
        while (OUTSTANDING !== 4'd2 && t < 50) begin
            step();
            t++;
        end
        chk("drain_setup_in_time", t < 50, 1);
        ENABLE = 1'b0;
        s0 = start_cnt;
        repeat (10) step();
        chk("drain_no_start", start_cnt - s0, 0);
        chk("drain_busy", BUSY, 1);
        add_done(1);
        step();
        step();
        add_done(1);
        step();
        chk("drain_busy_last", BUSY, 1);
        step();
        chk("drain_idle", BUSY, 0);
        chk("drain_outstanding", OUTSTANDING, 0);

        // Error cases: release with all credits home, completion with none outstanding
        auto_dma = 0; aempty_pct = 0;
        step();
        start_run(28'h0300000, 28'h0000100, 8'd2);
        step();
        step();
        chk("err_before_rel", ERR, 0);
        HOST_REL = 1'b1;
        step();
        chk("err_rel_full", ERR, 1);
        ENABLE = 1'b0;
        step();
        step();
        chk("err_stop_idle", BUSY, 0);
        chk("err_sticky", ERR, 1);
        start_run(28'h0300000, 28'h0000100, 8'd2);
        step();
        chk("err_clear_on_start", ERR, 0);
        dma_if.DMA_DONE_CNT = dma_if.DMA_DONE_CNT + 16'd1;
        step();
        chk("err_stale_done", ERR, 1);
        chk("err_stale_no_buf_done", BUF_DONE, 0);
        chk("err_stale_outstanding", OUTSTANDING, 0);
        ENABLE = 1'b0;
        repeat (3) step();
        chk("err_end_idle", BUSY, 0);

        // Randomized rings, including NUM_BUFS = 0
        for (int r = 0; r < 4; r++) begin
            nb  = (r == 0) ? 0 : int'($urandom_range(5, 1));
            tot = ((nb == 0) ? 1 : nb) + int'($urandom_range(6, 0));
            run_ring(28'($urandom), 28'($urandom_range(65535, 16)), 8'(nb), tot, 1, 8, 50, 80);
        end

        // DONE_CNT wrap 0xFFFF -> 0x0000 during a run, plus 28-bit address wrap
        aempty_pct = 100;
        dma_if.DMA_DONE_CNT = 16'hFFFF;
        repeat (65545) @(negedge CLK);
        chk("stale_catchup_err", ERR, 1);
        run_ring(28'hFFFFF00, 28'h0000100, 8'd2, 3, 2, 5, 100, 100);

        // Asynchronous reset in the middle of a run
        auto_dma = 1; auto_rel = 0; lat_min = 6; lat_max = 8; aempty_pct = 100;
        start_run(28'h0400000, 28'h0000040, 8'd3);
        repeat (3) push_start();
        t = 0;
        while (OUTSTANDING === 4'd0 && t < 50) begin
            step();
            t++;
        end
        chk("reset_setup_in_time", t < 50, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check_zero("async_reset");
        ENABLE = 1'b0;
        auto_dma = 0;
        dma_if.DMA_DONE_CNT = '0;
        exp_start_q.delete();
        exp_idx_q.delete();
        due_q.delete();
        step();
        step();
        RST_N = 1'b1;
        step();
        run_ring(28'h0500000, 28'h0000200, 8'd2, 4, 1, 6, 70, 90);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
